// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte register between NUM_REQ
// byte-stream requesters; the grant is held per burst, capped at MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_data_ready,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_data_valid,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_busy,
    output logic                   o_trunc
);

    localparam int                IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0]     LAST_INIT = IW'(NUM_REQ - 1);
    localparam logic [7:0]        MAX_CNT   = 8'(MAX_BURST);
    localparam logic [NUM_REQ-1:0] ONE_1H   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t               r_state,      w_state;
    logic [IW-1:0]        r_owner,      w_owner;
    logic [IW-1:0]        r_last_owner, w_last_owner;
    logic [7:0]           r_byte_cnt,   w_byte_cnt;
    logic [7:0]           r_tx_data,    w_tx_data;
    logic                 r_tx_valid,   w_tx_valid;
    logic [NUM_REQ-1:0]   r_grant,      w_grant;
    logic                 r_trunc,      w_trunc;

    logic [IW-1:0]        w_pick;
    logic                 w_found;
    logic                 w_hit;
    logic [IW-1:0]        w_idx;
    logic                 w_space;
    logic                 w_accept;
    logic [7:0]           w_cnt_inc;
    logic [7:0]           w_owner_byte;

    // Round-robin scan starting just after the previous owner
    always_comb begin
        w_pick  = r_last_owner;
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_idx   = r_last_owner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx   = IW'((int'(r_last_owner) + k) % NUM_REQ);
            w_hit   = !w_found && req_valid[w_idx];
            w_pick  = w_hit ? w_idx : w_pick;
            w_found = w_found | w_hit;
        end
    end

    assign w_space      = !r_tx_valid || tx_data_ready;
    assign w_accept     = (r_state == S_XFER) && req_valid[r_owner] && w_space;
    assign w_cnt_inc    = r_byte_cnt + 8'd1;
    assign w_owner_byte = req_data[{r_owner, 3'b000} +: 8];

    // Only the owner sees ready, and only when the output register has room
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if ((r_state == S_XFER) && w_space) begin
            req_ready[r_owner] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Next-state and next-output computation
    always_comb begin
        w_state      = r_state;
        w_owner      = r_owner;
        w_last_owner = r_last_owner;
        w_byte_cnt   = r_byte_cnt;
        w_tx_data    = r_tx_data;
        w_tx_valid   = r_tx_valid && !tx_data_ready;
        w_grant      = r_grant;
        w_trunc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_byte_cnt = 8'd0;
                if (|req_valid) begin
                    w_owner = w_pick;
                    w_grant = ONE_1H << w_pick;
                    w_state = S_XFER;
                end else begin
                    w_grant = {NUM_REQ{1'b0}};
                end
            end
            S_XFER: begin
                if (w_accept) begin
                    w_tx_data  = w_owner_byte;
                    w_tx_valid = 1'b1;
                    w_byte_cnt = w_cnt_inc;
                    if (req_last[r_owner] || (w_cnt_inc == MAX_CNT)) begin
                        w_state      = S_IDLE;
                        w_last_owner = r_owner;
                        w_grant      = {NUM_REQ{1'b0}};
                        w_trunc      = !req_last[r_owner];
                    end else begin
                        w_state = S_XFER;
                    end
                end else begin
                    w_state = S_XFER;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_grant = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= {IW{1'b0}};
            r_last_owner <= LAST_INIT;
            r_byte_cnt   <= 8'd0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_grant      <= {NUM_REQ{1'b0}};
            r_trunc      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_owner      <= w_owner;
            r_last_owner <= w_last_owner;
            r_byte_cnt   <= w_byte_cnt;
            r_tx_data    <= w_tx_data;
            r_tx_valid   <= w_tx_valid;
            r_grant      <= w_grant;
            r_trunc      <= w_trunc;
        end
    end

    assign o_tx_data       = r_tx_data;
    assign o_tx_data_valid = r_tx_valid;
    assign o_grant         = r_grant;
    assign o_trunc         = r_trunc;
    assign o_busy          = (r_state == S_XFER) || r_tx_valid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues drive the DUT,
// a forked monitor checks every byte the UART side takes against the expected queue.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid, req_last, req_ready, o_grant;
    logic [23:0] req_data;
    logic        tx_data_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_data_valid, o_busy, o_trunc;

    logic [8:0]  rq [3][$];
    logic [7:0]  exp_q [$];
    logic [2:0]  manual;
    int          n_chk, n_fail;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(3), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data_ready(tx_data_ready),
        .o_tx_data(o_tx_data), .o_tx_data_valid(o_tx_data_valid),
        .o_grant(o_grant), .o_busy(o_busy), .o_trunc(o_trunc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (!manual[i]) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = rq[i][0][7:0];
                    req_last[i]         = rq[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    endtask

    // One clock: handshakes sampled at negedge, queues advanced after the edge
    task automatic cyc();
        logic [2:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (acc[i] && !manual[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        drive();
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while (b < 300 && !(rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0
                            && exp_q.size() == 0 && !o_busy)) begin
            cyc();
            b++;
        end
        chk(name, 32'(b < 300), 32'd1);
    endtask

    logic [2:0] rr_exp [6];

    initial begin
        n_chk = 0; n_fail = 0;
        manual = 3'b000;
        req_valid = 3'b000; req_last = 3'b000; req_data = 24'h0;
        tx_data_ready = 1'b0;
        rst = 1'b1;
        rr_exp = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

        fork
            forever begin
                @(negedge clk);
                if (!rst && o_tx_data_valid && tx_data_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none at %0t", o_tx_data, $time);
                    end else begin
                        chk("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_valid", 32'(o_tx_data_valid), 32'd0);
        chk("rst_data", 32'(o_tx_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_trunc", 32'(o_trunc), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // "HI" burst from requester 0
        tx_data_ready = 1'b1;
        push(0, 8'h48, 1'b0); push(0, 8'h49, 1'b1);
        exp_q.push_back(8'h48); exp_q.push_back(8'h49);
        drive();
        cyc();
        chk("hi_grant", 32'(o_grant), 32'd1);
        chk("hi_busy_grant", 32'(o_busy), 32'd1);
        cyc();
        chk("hi_grant_hold", 32'(o_grant), 32'd1);
        chk("hi_first_byte", 32'(o_tx_data), 32'h48);
        cyc();
        chk("hi_release", 32'(o_grant), 32'd0);
        chk("hi_busy_pending", 32'(o_busy), 32'd1);
        cyc();
        chk("hi_busy_drop", 32'(o_busy), 32'd0);
        drain("hi_drain");

        // Round robin with one-byte bursts; last owner is 0 so 1 goes first
        for (int r = 0; r < 3; r++) begin
            push(r, 8'hA0 + 8'(r), 1'b1);
            push(r, 8'hA0 + 8'(r), 1'b1);
        end
        for (int b = 0; b < 2; b++) begin
            exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA0);
        end
        drive();
        for (int b = 0; b < 6; b++) begin
            cyc();
            chk("rr_grant", 32'(o_grant), 32'(rr_exp[b]));
            cyc();
            chk("rr_gap", 32'(o_grant), 32'd0);
        end
        drain("rr_drain");

        // Output stall mid-burst
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
        exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        drive();
        cyc();
        cyc();
        tx_data_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_valid", 32'(o_tx_data_valid), 32'd1);
            chk("stall_data", 32'(o_tx_data), 32'h10);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        tx_data_ready = 1'b1;
        drain("stall_drain");

        // Burst limit: requester 1 streams 20 bytes, requester 2 waiting
        for (int k = 0; k < 20; k++) push(1, 8'h20 + 8'(k), k == 19);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'h20 + 8'(k));
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
        for (int k = 16; k < 20; k++) exp_q.push_back(8'h20 + 8'(k));
        drive();
        cyc();
        chk("trunc_grant1", 32'(o_grant), 32'd2);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 15) begin
                chk("trunc_early", 32'(o_trunc), 32'd0);
                chk("trunc_hold", 32'(o_grant), 32'd2);
            end
        end
        chk("trunc_pulse", 32'(o_trunc), 32'd1);
        chk("trunc_release", 32'(o_grant), 32'd0);
        cyc();
        chk("trunc_one_cycle", 32'(o_trunc), 32'd0);
        chk("trunc_grant2", 32'(o_grant), 32'd4);
        drain("trunc_drain");

        // Non-owner requester 2 toggles during requester 0's burst
        manual = 3'b100;
        req_valid[2] = 1'b0; req_last[2] = 1'b0;
        for (int k = 0; k < 4; k++) push(0, 8'h50 + 8'(k), k == 3);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h50 + 8'(k));
        drive();
        cyc();
        chk("nonowner_grant", 32'(o_grant), 32'd1);
        for (int k = 0; k < 4; k++) begin
            req_valid[2]    = (k % 2 == 0);
            req_data[23:16] = 8'hE0 + 8'(k);
            req_last[2]     = 1'b1;
            cyc();
            chk("nonowner_ready", 32'(req_ready[2]), 32'd0);
        end
        req_valid[2] = 1'b0; req_last[2] = 1'b0;
        manual = 3'b000;
        drive();
        drain("nonowner_drain");

        // Reset while an output byte is pending
        tx_data_ready = 1'b0;
        push(1, 8'h60, 1'b0); push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
        drive();
        cyc();
        chk("mrst_grant", 32'(o_grant), 32'd2);
        cyc();
        chk("mrst_pending", 32'(o_tx_data_valid), 32'd1);
        chk("mrst_data", 32'(o_tx_data), 32'h60);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) rq[i].delete();
        exp_q.delete();
        drive();
        cyc();
        chk("mrst_valid", 32'(o_tx_data_valid), 32'd0);
        chk("mrst_data0", 32'(o_tx_data), 32'd0);
        chk("mrst_grant0", 32'(o_grant), 32'd0);
        chk("mrst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        tx_data_ready = 1'b1;
        push(0, 8'h70, 1'b1); push(1, 8'h71, 1'b1);
        exp_q.push_back(8'h70); exp_q.push_back(8'h71);
        drive();
        cyc();
        chk("mrst_restart0", 32'(o_grant), 32'd1);
        drain("mrst_drain");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
